// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg
// Shared types and helpers for the pipelined lower-part-OR approximate adder.
//   loa_calc  : approximate sum, exact sum and absolute error for a given
//               number of approximated low bits (operands zero-extended to MAX_W).
//   stats_t   : statistics record (transaction count, violation count, max error).
//   sat_inc   : saturating increment limited to a given counter width.
// Widths are carried at MAX_W / MAX_CNT_W; users slice down to their parameters,
// and synthesis trims the constant-zero upper bits.
package approx_adder_pkg;

    localparam int unsigned MAX_W     = 64;
    localparam int unsigned MAX_CNT_W = 32;

    typedef struct packed {
        logic [MAX_W:0] approx;
        logic [MAX_W:0] exact;
        logic [MAX_W:0] err;
    } loa_res_t;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] txn;
        logic [MAX_CNT_W-1:0] viol;
        logic [MAX_W:0]       max_err;
    } stats_t;

    // Low k bits are OR-ed; the carry into the exact upper part is the AND of
    // the top approximated bit pair, which recovers the most likely lost carry.
    function automatic loa_res_t loa_calc(input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input int unsigned      k);
        loa_res_t       r;
        logic [MAX_W:0] one;
        logic [MAX_W:0] low_mask;
        logic [MAX_W:0] low;
        logic [MAX_W:0] high;
        logic [MAX_W-1:0] ab_sh;
        logic           cin;
        one      = {{MAX_W{1'b0}}, 1'b1};
        low_mask = (one << k) - one;
        low      = {1'b0, a | b} & low_mask;
        if (k == 32'd0) begin
            ab_sh = {MAX_W{1'b0}};
            cin   = 1'b0;
        end else begin
            ab_sh = (a & b) >> (k - 32'd1);
            cin   = ab_sh[0];
        end
        high     = ({1'b0, a} >> k) + ({1'b0, b} >> k) + {{MAX_W{1'b0}}, cin};
        r.approx = (high << k) | low;
        r.exact  = {1'b0, a} + {1'b0, b};
        if (r.exact >= r.approx) begin
            r.err = r.exact - r.approx;
        end else begin
            r.err = r.approx - r.exact;
        end
        return r;
    endfunction

    // Increments v by one when inc is set, holding at 2^w - 1.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                     input logic                 inc,
                                                     input int unsigned          w);
        logic [MAX_CNT_W-1:0] limit;
        limit = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - w);
        if (inc && (v < limit)) begin
            return v + {{(MAX_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/approx_adder_et_pipe_core.sv
// loa_adder_core
// Combinational lower-part-OR adder with an exact reference path.
// Ports:
//   a, b        : WIDTH-bit operands
//   exact_mode  : 1 selects the exact sum (error is then zero)
//   sum         : WIDTH+1-bit selected sum
//   err         : WIDTH+1-bit |exact - sum|
// WIDTH must be at most MAX_W-1.
module loa_adder_core
    import approx_adder_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             exact_mode,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   err
);

    loa_res_t res;
    logic     unused_res_hi;

    assign res = loa_calc(MAX_W'(a), MAX_W'(b), APPROX_BITS);

    // Results never exceed WIDTH+1 bits; the upper bits are structurally zero.
    assign unused_res_hi = ^{res.approx[MAX_W:WIDTH+1], res.exact[MAX_W:WIDTH+1],
                             res.err[MAX_W:WIDTH+1]};

    // Select exact or approximate result for this transaction.
    always_comb begin
        sum = res.approx[WIDTH:0];
        err = res.err[WIDTH:0];
        if (exact_mode) begin
            sum = res.exact[WIDTH:0];
            err = {(WIDTH+1){1'b0}};
        end else begin
            sum = res.approx[WIDTH:0];
            err = res.err[WIDTH:0];
        end
    end

endmodule

// File: rtl/approx_adder_et_pipe.sv
// approx_adder_et_pipe
// Two-stage elastic pipeline around loa_adder_core with error-threshold check
// and saturating statistics.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready, a, b, exact_mode : operand input handshake
//   out_valid/out_ready, sum, err, err_flag : result output handshake
//   clear_stats              : synchronous clear of the statistics
//   txn_count, viol_count, max_err : statistics since last clear/reset
module approx_adder_et_pipe
    import approx_adder_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 2,
    parameter int unsigned ET          = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             exact_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   err,
    output logic             err_flag,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] viol_count,
    output logic [WIDTH:0]   max_err
);

    localparam logic [WIDTH:0] ET_W = (WIDTH+1)'(ET);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH:0]   s2_sum_q, s2_sum_d;
    logic [WIDTH:0]   s2_err_q, s2_err_d;
    logic             s2_flag_q, s2_flag_d;
    stats_t           stats_q, stats_d;

    logic             s1_load;
    logic             s2_load;
    logic             out_hs;
    logic [WIDTH:0]   core_sum;
    logic [WIDTH:0]   core_err;

    loa_adder_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .a          (s1_a_q),
        .b          (s1_b_q),
        .exact_mode (s1_mode_q),
        .sum        (core_sum),
        .err        (core_err)
    );

    // in_ready depends on out_ready and stage occupancy only, never on in_valid.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign out_hs   = s2_valid_q && out_ready;

    // Stage next-state: data registers only capture on a valid transfer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_err_d   = s2_err_q;
        s2_flag_d  = s2_flag_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = a;
                s1_b_d    = b;
                s1_mode_d = exact_mode;
            end else begin
                s1_a_d    = s1_a_q;
                s1_b_d    = s1_b_q;
                s1_mode_d = s1_mode_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d  = core_sum;
                s2_err_d  = core_err;
                s2_flag_d = (core_err > ET_W);
            end else begin
                s2_sum_d  = s2_sum_q;
                s2_err_d  = s2_err_q;
                s2_flag_d = s2_flag_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Statistics next-state: clear takes priority over a coinciding handshake.
    always_comb begin
        stats_d = stats_q;
        if (clear_stats) begin
            stats_d = '0;
        end else if (out_hs) begin
            stats_d.txn  = sat_inc(stats_q.txn, 1'b1, CNT_W);
            stats_d.viol = sat_inc(stats_q.viol, s2_flag_q, CNT_W);
            if ((MAX_W+1)'(s2_err_q) > stats_q.max_err) begin
                stats_d.max_err = (MAX_W+1)'(s2_err_q);
            end else begin
                stats_d.max_err = stats_q.max_err;
            end
        end else begin
            stats_d = stats_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= {WIDTH{1'b0}};
            s1_b_q     <= {WIDTH{1'b0}};
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= {(WIDTH+1){1'b0}};
            s2_err_q   <= {(WIDTH+1){1'b0}};
            s2_flag_q  <= 1'b0;
            stats_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_err_q   <= s2_err_d;
            s2_flag_q  <= s2_flag_d;
            stats_q    <= stats_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign sum        = s2_sum_q;
    assign err        = s2_err_q;
    assign err_flag   = s2_flag_q;
    assign txn_count  = stats_q.txn[CNT_W-1:0];
    assign viol_count = stats_q.viol[CNT_W-1:0];
    assign max_err    = stats_q.max_err[WIDTH:0];

endmodule
